mem_arbiter: RTL and testbench

- Two-master round-robin arbiter for the picorv32 native memory interface (valid/ready, addr, wdata, wstrb, rdata, instr).
- Shares one memory/MMIO slave between two requesters, e.g. CPU core plus a DMA engine or a second core.
- Each granted request is latched into an internal buffer and driven to the slave until the slave completes it.
- Sits between the masters' mem_* ports and the memory model / bus decoder.

---
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter for the picorv32 native memory
// interface. A granted request is latched and presented to the shared slave
// until the slave completes it; the master that did not win last time wins
// any tie.
// Optional feature: define MEM_ARBITER_TIMEOUT_EN to abort transactions the
// slave leaves hanging for TIMEOUT_CYCLES busy cycles.
//
// Handshake: a master request is live while mX_mem_valid=1; the arbiter
// answers with a single-cycle mX_mem_ready, and the master must drop valid
// in the following cycle. On the slave side s_mem_valid stays high with
// stable payload until the cycle in which s_mem_ready=1 is sampled.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_mem_valid,
  input  logic        m0_mem_instr,
  input  logic [31:0] m0_mem_addr,
  input  logic [31:0] m0_mem_wdata,
  input  logic [3:0]  m0_mem_wstrb,
  output logic        m0_mem_ready,
  output logic [31:0] m0_mem_rdata,
  input  logic        m1_mem_valid,
  input  logic        m1_mem_instr,
  input  logic [31:0] m1_mem_addr,
  input  logic [31:0] m1_mem_wdata,
  input  logic [3:0]  m1_mem_wstrb,
  output logic        m1_mem_ready,
  output logic [31:0] m1_mem_rdata,
  output logic        s_mem_valid,
  output logic        s_mem_instr,
  output logic [31:0] s_mem_addr,
  output logic [31:0] s_mem_wdata,
  output logic [3:0]  s_mem_wstrb,
  input  logic        s_mem_ready,
  input  logic [31:0] s_mem_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state;
  state_t state_next;
  logic   last_grant;   // 0: master 0 was served last, 1: master 1
  logic   take;         // accept a request this cycle
  logic   req_sel;      // which master is accepted (0 or 1)
  logic   finish;       // in-flight transaction ends this cycle
  logic   abort;        // timeout abort this cycle
  logic   complete;     // completion pulse towards the owner

`ifdef MEM_ARBITER_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // Count busy cycles in which the slave has not answered.
  always_ff @(posedge clk) begin
    if (reset || take) begin
      tmo_cnt <= '0;
    end else if (state == BUSY && !s_mem_ready) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  // A slave answer in the same cycle always beats the abort.
  assign abort       = (state == BUSY) && !s_mem_ready &&
                       (tmo_cnt == 16'(TIMEOUT_CYCLES));
  assign timeout_err = abort && !reset;
`else
  assign abort       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and arbitration decision.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    req_sel    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (m0_mem_valid || m1_mem_valid) begin
          take       = 1'b1;
          req_sel    = (m0_mem_valid && m1_mem_valid) ? ~last_grant : m1_mem_valid;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (s_mem_ready || abort) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch towards the slave plus ownership bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_mem_valid <= 1'b0;
      s_mem_instr <= 1'b0;
      s_mem_addr  <= '0;
      s_mem_wdata <= '0;
      s_mem_wstrb <= '0;
      grant       <= 2'b00;
      last_grant  <= 1'b1;
    end else if (take) begin
      s_mem_valid <= 1'b1;
      s_mem_instr <= req_sel ? m1_mem_instr : m0_mem_instr;
      s_mem_addr  <= req_sel ? m1_mem_addr  : m0_mem_addr;
      s_mem_wdata <= req_sel ? m1_mem_wdata : m0_mem_wdata;
      s_mem_wstrb <= req_sel ? m1_mem_wstrb : m0_mem_wstrb;
      grant       <= req_sel ? 2'b10 : 2'b01;
    end else if (finish) begin
      s_mem_valid <= 1'b0;
      grant       <= 2'b00;
      last_grant  <= grant[1];
    end
  end

  // Completion is forwarded combinationally, only to the owner, never in reset.
  assign complete     = finish && !reset;
  assign m0_mem_ready = complete && grant[0];
  assign m1_mem_ready = complete && grant[1];
  assign m0_mem_rdata = (m0_mem_ready && s_mem_ready) ? s_mem_rdata : 32'h0;
  assign m1_mem_rdata = (m1_mem_ready && s_mem_ready) ? s_mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized stimulus for mem_arbiter, checked
// cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_valid [2];
  logic        m_instr [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_wstrb [2];
  logic        s_ready;
  logic [31:0] s_rdata;

  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_instr;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;
  logic        timeout_err;

  // Reference model: the transaction currently owned by the slave.
  logic        mdl_busy;
  int          mdl_owner;
  int          mdl_last;
  logic        mdl_instr;
  logic [31:0] mdl_addr, mdl_wdata;
  logic [3:0]  mdl_wstrb;
  logic        just_reset;
  logic [1:0]  grant_q [$];
  logic        done [2];
  int          gap  [2];

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clk          (clk),
    .reset        (rst),
    .m0_mem_valid (m_valid[0]),
    .m0_mem_instr (m_instr[0]),
    .m0_mem_addr  (m_addr[0]),
    .m0_mem_wdata (m_wdata[0]),
    .m0_mem_wstrb (m_wstrb[0]),
    .m0_mem_ready (m0_ready),
    .m0_mem_rdata (m0_rdata),
    .m1_mem_valid (m_valid[1]),
    .m1_mem_instr (m_instr[1]),
    .m1_mem_addr  (m_addr[1]),
    .m1_mem_wdata (m_wdata[1]),
    .m1_mem_wstrb (m_wstrb[1]),
    .m1_mem_ready (m1_ready),
    .m1_mem_rdata (m1_rdata),
    .s_mem_valid  (s_valid),
    .s_mem_instr  (s_instr),
    .s_mem_addr   (s_addr),
    .s_mem_wdata  (s_wdata),
    .s_mem_wstrb  (s_wstrb),
    .s_mem_ready  (s_ready),
    .s_mem_rdata  (s_rdata),
    .grant        (grant),
    .timeout_err  (timeout_err)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: entered at negedge with inputs already driven.
  task automatic cycle();
    logic       r0, r1;
    logic [1:0] exp_grant;
    #1;
    r0 = !rst && mdl_busy && mdl_owner == 0 && s_ready;
    r1 = !rst && mdl_busy && mdl_owner == 1 && s_ready;
    exp_grant = !mdl_busy ? 2'b00 : (mdl_owner == 0 ? 2'b01 : 2'b10);
    chk("m0_ready", m0_ready, r0);
    chk("m1_ready", m1_ready, r1);
    chk("s_valid", s_valid, mdl_busy);
    chk("grant", grant, exp_grant);
    chk("timeout_err", timeout_err, 1'b0);
    if (r0) chk("m0_rdata", m0_rdata, s_rdata);
    if (r1) chk("m1_rdata", m1_rdata, s_rdata);
    if (!(mdl_busy && mdl_owner == 0)) chk("m0_rdata_idle", m0_rdata, 32'h0);
    if (!(mdl_busy && mdl_owner == 1)) chk("m1_rdata_idle", m1_rdata, 32'h0);
    if (mdl_busy) begin
      chk("s_addr", s_addr, mdl_addr);
      chk("s_wdata", s_wdata, mdl_wdata);
      chk("s_wstrb", s_wstrb, mdl_wstrb);
      chk("s_instr", s_instr, mdl_instr);
    end else if (just_reset) begin
      chk("rst_addr", s_addr, 32'h0);
      chk("rst_wdata", s_wdata, 32'h0);
      chk("rst_wstrb", s_wstrb, 4'h0);
      chk("rst_instr", s_instr, 1'b0);
    end
    done[0] = r0;
    done[1] = r1;
    @(posedge clk);
    // Model update from the rules: serve the single requester, or the one
    // not served last when both ask; hold until the slave answers.
    if (rst) begin
      mdl_busy = 1'b0;
      mdl_last = 1;
    end else if (mdl_busy) begin
      if (s_ready) begin
        mdl_busy = 1'b0;
        mdl_last = mdl_owner;
      end
    end else if (m_valid[0] || m_valid[1]) begin
      if (m_valid[0] && m_valid[1]) mdl_owner = 1 - mdl_last;
      else                          mdl_owner = m_valid[1] ? 1 : 0;
      mdl_busy  = 1'b1;
      mdl_instr = m_instr[mdl_owner];
      mdl_addr  = m_addr[mdl_owner];
      mdl_wdata = m_wdata[mdl_owner];
      mdl_wstrb = m_wstrb[mdl_owner];
      grant_q.push_back(mdl_owner == 0 ? 2'b01 : 2'b10);
    end
    just_reset = rst;
    @(negedge clk);
  endtask

  task automatic new_req(input int i);
    m_valid[i] = 1'b1;
    m_instr[i] = 1'($urandom_range(0, 1));
    m_addr[i]  = $urandom & 32'hffff_fffc;
    m_wdata[i] = $urandom;
    m_wstrb[i] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
  endtask

  // Random master/slave behaviour for one cycle.
  task automatic drive(input int gmax);
    for (int i = 0; i < 2; i++) begin
      if (done[i]) begin
        m_valid[i] = 1'b0;
        gap[i] = $urandom_range(0, gmax);
      end else if (!m_valid[i]) begin
        if (gap[i] == 0) new_req(i);
        else gap[i]--;
      end else if ($urandom_range(0, 3) == 0) begin
        m_addr[i] = $urandom & 32'hffff_fffc;
      end
    end
    s_ready = ($urandom_range(0, 2) == 0);
    s_rdata = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_valid[0] = 1'b0;
    m_valid[1] = 1'b0;
    s_ready = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic instr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    m_valid[i] = 1'b1;
    m_instr[i] = instr;
    m_addr[i]  = addr;
    m_wdata[i] = wdata;
    m_wstrb[i] = wstrb;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0; m_instr[i] = 1'b0; m_addr[i] = '0;
      m_wdata[i] = '0;   m_wstrb[i] = '0;   done[i] = 1'b0; gap[i] = 0;
    end
    s_ready = 1'b0; s_rdata = '0; rst = 1'b1;
    mdl_busy = 1'b0; mdl_owner = 0; mdl_last = 1; just_reset = 1'b0;
    mdl_instr = 1'b0; mdl_addr = '0; mdl_wdata = '0; mdl_wstrb = '0;
    @(negedge clk);

    // Single m0 read, slave answers two cycles after s_mem_valid.
    do_reset();
    set_req(0, 1'b1, 32'h0000_0008, 32'h0, 4'h0);
    cycle();
    m_valid[0] = 1'b0;   // request latched; value no longer matters
    cycle();
    cycle();
    s_ready = 1'b1; s_rdata = 32'h0000_a103;
    chk("t1_addr", s_addr, 32'h0000_0008);
    cycle();
    s_ready = 1'b0;
    cycle();

    // Both from reset: m0 write first, then m1 read.
    do_reset();
    grant_q.delete();
    set_req(0, 1'b0, 32'h0000_03fc, 32'h0000_0005, 4'hf);
    set_req(1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
    s_ready = 1'b1; s_rdata = 32'h1234_5678;
    cycle();
    cycle();
    m_valid[0] = 1'b0;
    cycle();
    cycle();
    m_valid[1] = 1'b0;
    s_ready = 1'b0;
    cycle();
    chk("t2_count", grant_q.size(), 2);
    if (grant_q.size() == 2) begin
      chk("t2_first", grant_q[0], 2'b01);
      chk("t2_second", grant_q[1], 2'b10);
    end

    // Continuous contention: strict alternation.
    do_reset();
    grant_q.delete();
    gap[0] = 0; gap[1] = 0; done[0] = 1'b0; done[1] = 1'b0;
    n = 0;
    while (grant_q.size() < 6 && n < 300) begin
      drive(0);
      cycle();
      n++;
    end
    chk("t3_count_reached", (grant_q.size() >= 6), 1'b1);
    for (int k = 0; k < 6 && k < grant_q.size(); k++)
      chk("t3_alternate", grant_q[k], (k % 2 == 0) ? 2'b01 : 2'b10);

    // m1 changes its address while its request is in flight.
    do_reset();
    set_req(1, 1'b0, 32'h0000_0020, 32'h0, 4'h0);
    cycle();
    m_addr[1] = 32'h0000_0040;
    cycle();
    chk("t4_addr_hold", s_addr, 32'h0000_0020);
    cycle();
    s_ready = 1'b1; s_rdata = 32'hcafe_0001;
    cycle();
    m_valid[1] = 1'b0; s_ready = 1'b0;
    cycle();

    // Reset in the middle of a transaction, then m0 wins the tie.
    do_reset();
    set_req(0, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
    cycle();
    cycle();
    rst = 1'b1; s_ready = 1'b1;
    set_req(1, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
    cycle();
    rst = 1'b0; s_ready = 1'b0;
    grant_q.delete();
    cycle();
    chk("t5_tie_count", grant_q.size(), 1);
    if (grant_q.size() >= 1) chk("t5_tie_m0", grant_q[0], 2'b01);
    s_ready = 1'b1;
    cycle();
    m_valid[0] = 1'b0; s_ready = 1'b0;
    done[0] = 1'b0; done[1] = 1'b0;

    // Randomized traffic with idle gaps and slave wait states.
    for (int c = 0; c < 600; c++) begin
      drive(3);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
